p1n3ser_seq: RTL and testbench

- Clocked precharge/evaluate sequencer for the P1N3SERX1 dynamic stage; sits directly upstream of it and consumes its output.
- Drives the cell's precharge gate (A, active-low) and the three series evaluate gates (B, C, D).
- Synchronises the returned node Z into the clock domain, captures it, and checks it against the expected NAND3 result.
- Presents the result on a valid/ready handshake. One transaction in flight at a time.

---
 rtl/p1n3ser_pkg.sv | 21 ++
 rtl/rail_sync.sv | 24 ++
 rtl/p1n3ser_seq.sv | 138 +++++++++++++
 tb/tb_p1n3ser_seq.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/p1n3ser_pkg.sv
// Shared types and helpers for the P1N3SERX1 precharge/evaluate sequencer.
package p1n3ser_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRECH = 3'd1,
        GAP   = 3'd2,
        EVAL  = 3'd3,
        HOLD  = 3'd4
    } state_t;

    localparam int unsigned IDX_B = 0;
    localparam int unsigned IDX_C = 1;
    localparam int unsigned IDX_D = 2;

    // A healthy cell discharges Z only when all three series gates conduct.
    function automatic logic exp_z(input logic [2:0] req);
        return ~(req[IDX_B] & req[IDX_C] & req[IDX_D]);
    endfunction

endpackage

// File: rtl/rail_sync.sv
// Multi-flop synchroniser for an asynchronous single-bit rail; only the last stage is visible.
module rail_sync #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/p1n3ser_seq.sv
// Precharge/evaluate sequencer for the P1N3SERX1 dynamic NAND3 stage with result checking.
// Optional `ERR_STICKY_EN adds a sticky error flag output.
module p1n3ser_seq
    import p1n3ser_pkg::*;
#(
    parameter int unsigned PRECH_CYC   = 2,
    parameter int unsigned EVAL_CYC    = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_data,
    output logic       pch_n,
    output logic [2:0] ev,
    input  logic       node_z,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_data,
    output logic       out_err
`ifdef ERR_STICKY_EN
    ,
    output logic       err_sticky
`endif
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         req_q, req_d;
    logic               z_sync;
    logic               capture;
    logic               pch_n_d;
    logic [2:0]         ev_d;
    logic               out_valid_d, out_data_d, out_err_d;

    rail_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_z_sync (
        .clk_i (CLK),
        .rst_i (RST),
        .d_i   (node_z),
        .q_o   (z_sync)
    );

    assign in_ready = (state_q == IDLE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    req_d   = in_data;
                    cnt_d   = CNT_W'(PRECH_CYC - 1);
                    state_d = PRECH;
                end
            end
            PRECH: begin
                if (cnt_q == '0) state_d = GAP;
                else             cnt_d   = cnt_q - 1'b1;
            end
            GAP: begin
                // Sync latency is folded into the evaluate window so the capture sees settled Z.
                cnt_d   = CNT_W'(EVAL_CYC + SYNC_STAGES - 1);
                state_d = EVAL;
            end
            EVAL: begin
                if (cnt_q == '0) state_d = HOLD;
                else             cnt_d   = cnt_q - 1'b1;
            end
            HOLD: begin
                if (out_valid && out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Gate drives follow the next state, so precharge and evaluate switch on the same edge
    // as the state and can never overlap.
    always_comb begin
        pch_n_d     = !(state_d == IDLE || state_d == PRECH);
        ev_d        = (state_d == EVAL) ? req_d : 3'b000;
        capture     = (state_q == EVAL) && (state_d == HOLD);
        out_valid_d = out_valid;
        out_data_d  = out_data;
        out_err_d   = out_err;
        if (capture) begin
            out_valid_d = 1'b1;
            out_data_d  = z_sync;
            out_err_d   = (z_sync != exp_z(req_q));
        end else if (state_q == HOLD && state_d == IDLE) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pch_n     <= 1'b0;
            ev        <= 3'b000;
            out_valid <= 1'b0;
            out_data  <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            pch_n     <= pch_n_d;
            ev        <= ev_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            out_err   <= out_err_d;
        end
    end

`ifdef ERR_STICKY_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_sticky <= 1'b0;
        end else if (capture && out_err_d) begin
            err_sticky <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_p1n3ser_seq.sv
// Directed self-checking bench for p1n3ser_seq with a behavioural dynamic NAND3 cell model.
module tb_p1n3ser_seq;

    logic       CLK = 1'b0;
    logic       RST;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_data;
    logic       pch_n;
    logic [2:0] ev;
    logic       node_z;
    logic       out_valid;
    logic       out_ready;
    logic       out_data;
    logic       out_err;
`ifdef ERR_STICKY_EN
    logic       err_sticky;
`endif

    int checks = 0;
    int errors = 0;

    logic dyn   = 1'b1;
    logic fault = 1'b0;

    always #5 CLK = ~CLK;

    // Dynamic node: precharged high while A is low, discharged when all series gates are on,
    // otherwise keeps its charge.
    always @(pch_n or ev) begin
        if (!pch_n)            dyn = 1'b1;
        else if (ev == 3'b111) dyn = 1'b0;
    end
    assign node_z = dyn & ~fault;

    p1n3ser_seq dut (
        .CLK        (CLK),
        .RST        (RST),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .pch_n      (pch_n),
        .ev         (ev),
        .node_z     (node_z),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_err    (out_err)
`ifdef ERR_STICKY_EN
        ,
        .err_sticky (err_sticky)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Break-before-make must hold on every cycle.
    always @(negedge CLK) begin
        checks++;
        assert (!(pch_n === 1'b0 && ev !== 3'b000)) else begin
            errors++;
            $error("FAIL overlap: observed pch_n=%0b ev=%03b expected no overlap", pch_n, ev);
        end
    end

    // Runs one request starting at a negedge with the DUT idle; optionally back-pressures.
    task automatic run_txn(input logic [2:0] d, input logic flt, input logic bp);
        int         k;
        logic       ed, ee;
        logic [3:0] exp_pe;
        ed    = flt ? 1'b0 : ~&d;
        ee    = (ed != ~&d);
        fault = flt;
        chk("accept_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge CLK);
        in_valid = 1'b0;
        in_data  = ~d;
        chk("prech_start", {28'd0, pch_n, ev}, 32'd0);
        k = 0;
        while (!out_valid && k < 40) begin
            @(negedge CLK);
            k++;
            if (!out_valid) begin
                exp_pe = (k == 2) ? 4'b1000 : (k >= 3) ? {1'b1, d} : 4'b0000;
                chk("phase", {28'd0, pch_n, ev}, {28'd0, exp_pe});
            end
        end
        chk("latency", k, 32'd7);
        chk("out_data", {31'd0, out_data}, {31'd0, ed});
        chk("out_err", {31'd0, out_err}, {31'd0, ee});
        chk("hold_drive", {28'd0, pch_n, ev}, 32'h8);
        fault = 1'b0;
        if (bp) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = 3'b111;
            repeat (10) begin
                @(negedge CLK);
                chk("bp_stable", {28'd0, out_valid, out_data, out_err, in_ready},
                    {28'd0, 1'b1, ed, ee, 1'b0});
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(negedge CLK);
        chk("handshake", {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        int k;
        RST       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 3'b000;
        out_ready = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rst_state", {26'd0, pch_n, ev, out_valid, in_ready, out_data},
            {26'd0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0});
        RST = 1'b0;
        repeat (20) begin
            @(negedge CLK);
            chk("idle", {26'd0, pch_n, ev, out_valid, in_ready, out_err},
                {26'd0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0});
        end
`ifdef ERR_STICKY_EN
        chk("sticky_rst", {31'd0, err_sticky}, 32'd0);
`endif

        run_txn(3'b111, 1'b0, 1'b0);
        run_txn(3'b101, 1'b0, 1'b0);
`ifdef ERR_STICKY_EN
        chk("sticky_clean", {31'd0, err_sticky}, 32'd0);
`endif
        run_txn(3'b101, 1'b1, 1'b0);
`ifdef ERR_STICKY_EN
        chk("sticky_set", {31'd0, err_sticky}, 32'd1);
`endif
        run_txn(3'b011, 1'b0, 1'b0);
`ifdef ERR_STICKY_EN
        chk("sticky_keep", {31'd0, err_sticky}, 32'd1);
`endif

        run_txn(3'b110, 1'b0, 1'b1);
        run_txn(3'b111, 1'b0, 1'b0);

        // Reset in the middle of evaluation.
        in_valid = 1'b1;
        in_data  = 3'b111;
        @(negedge CLK);
        in_valid = 1'b0;
        k = 0;
        while (ev !== 3'b111 && k < 20) begin
            @(negedge CLK);
            k++;
        end
        chk("reach_eval", {29'd0, ev}, 32'd7);
        RST = 1'b1;
        #1;
        chk("rst_mid", {27'd0, pch_n, ev, out_valid}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_exit", {26'd0, pch_n, ev, out_valid, in_ready}, 32'd1);
`ifdef ERR_STICKY_EN
        chk("sticky_cleared", {31'd0, err_sticky}, 32'd0);
`endif
        run_txn(3'b111, 1'b0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            run_txn(3'($urandom_range(0, 7)), 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
